// File: rtl/alu_share_if.sv
// Bundles the request, ALU and response signals of alu_share_arbiter.
//   req0_* / req1_* : valid/ready request channels carrying operands and opcode
//   alu_*           : operands and opcode out to the external combinational ALU,
//                     result and carry-out back from it
//   rsp_*           : valid/ready response channel tagged with the requester id
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_cout,
    output rsp_valid, rsp_id, rsp_data, rsp_cout,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_cout,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle while the ALU settles on the
// registered operands, then RESP holds the tagged result until the consumer
// takes it. Completed responses are counted in ops_done.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : alu_share_if.slave (request, ALU and response channels)
//   busy      : high whenever the FSM is not in IDLE
//   ops_done  : completed response count, wraps modulo 2^CNT_W
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_if.slave       bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_id_q;   // requester granted most recently
  logic             pend_id_q;   // requester owning the operation in flight
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic             rsp_valid_q, rsp_id_q, rsp_cout_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [CNT_W-1:0] ops_q;

  logic             gnt0, gnt1, grant, rsp_fire;

  always_comb begin
    state_d  = state_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rsp_fire = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester not granted last wins; the rst gate keeps
        // ready low while reset is asserted.
        if (!rst) begin
          gnt0 = bus.req0_valid && (!bus.req1_valid || last_id_q);
          gnt1 = bus.req1_valid && (!bus.req0_valid || !last_id_q);
        end
        if (gnt0 || gnt1) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_fire = bus.rsp_ready;
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = gnt0 || gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;  // makes requester 0 win the first tie
      pend_id_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        alu_a_q   <= gnt1 ? bus.req1_a  : bus.req0_a;
        alu_b_q   <= gnt1 ? bus.req1_b  : bus.req0_b;
        alu_op_q  <= gnt1 ? bus.req1_op : bus.req0_op;
        pend_id_q <= gnt1;
      end
      // ALU output has had the whole EXEC cycle to settle on the held operands.
      if (state_q == EXEC) begin
        rsp_data_q  <= bus.alu_result;
        rsp_cout_q  <= bus.alu_cout;
        rsp_id_q    <= pend_id_q;
        rsp_valid_q <= 1'b1;
        last_id_q   <= pend_id_q;
      end
      if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
        ops_q       <= ops_q + 1'b1;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign busy           = (state_q != IDLE);
  assign ops_done       = ops_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  alu_share_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  // External ALU: {cout, result}
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} + {1'b0, ~b} + 33'd1;
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a ^ b};
      3'b101:  return {32'd0, ($signed(a) < $signed(b))};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {bus.alu_cout, bus.alu_result} = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        cout;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   got0   = 1'b0;
  bit   got1   = 1'b0;

  // Reference model: one operation at a time, response visible two cycles
  // after the grant cycle, ties go to whoever was not served last.
  bit   m_inflight = 1'b0;
  int   m_age      = 0;
  bit   m_last     = 1'b1;
  int   m_ops      = 0;
  rsp_t hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit          er0, er1, erv;
    logic [32:0] r;
    rsp_t        e;
    if (mon_en) begin
      er0 = !rst && !m_inflight && bus.req0_valid && (!bus.req1_valid || m_last);
      er1 = !rst && !m_inflight && bus.req1_valid && (!bus.req0_valid || !m_last);
      erv = m_inflight && (m_age >= 2);
      chk("req0_ready", 64'(bus.req0_ready), 64'(er0));
      chk("req1_ready", 64'(bus.req1_ready), 64'(er1));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
      chk("busy", 64'(busy), 64'(m_inflight));
      chk("ops_done", 64'(ops_done), 64'(m_ops % 4));
      if (erv && m_age > 2)
        chk("rsp_hold", 64'({bus.rsp_id, bus.rsp_data, bus.rsp_cout}), 64'(hold));
      if (erv && m_age == 2)
        hold = {bus.rsp_id, bus.rsp_data, bus.rsp_cout};

      if (bus.req0_valid && bus.req0_ready) begin
        r = alu_f(bus.req0_a, bus.req0_b, bus.req0_op);
        sb_q.push_back({1'b0, r[31:0], r[32]});
        got0 = 1'b1;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        r = alu_f(bus.req1_a, bus.req1_b, bus.req1_op);
        sb_q.push_back({1'b1, r[31:0], r[32]});
        got1 = 1'b1;
      end

      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0d data 0x%0h, expected no response at %0t",
                   bus.rsp_id, bus.rsp_data, $time);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          chk("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
        end
      end

      if (rst) begin
        m_inflight = 1'b0;
        m_age      = 0;
        m_last     = 1'b1;
        m_ops      = 0;
        sb_q.delete();
      end else if (m_inflight) begin
        if (erv && bus.rsp_ready) begin
          m_inflight = 1'b0;
          m_ops++;
        end else begin
          m_age++;
        end
      end else if (er0 || er1) begin
        m_inflight = 1'b1;
        m_age      = 1;
        m_last     = er1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic set1(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  task automatic wait_got(input string nm, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (got0 || got1) break;
    end
    if (i == bound) begin
      n_vec++; n_fail++;
      $display("FAIL %s: got no grant, expected one within %0d cycles", nm, bound);
    end
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (!busy && sb_q.size() == 0) break;
    end
    if (i == bound) begin
      n_vec++; n_fail++;
      $display("FAIL %s: got busy=%0d pending=%0d, expected idle within %0d cycles",
               nm, busy, sb_q.size(), bound);
    end
  endtask

  task automatic do_reset();
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_cout", 64'(bus.rsp_cout), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
    chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
    rst  = 1'b0;
    got0 = 1'b0;
    got1 = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 4)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit prev;
    bus.rsp_ready = 1'b1;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);

    // Single request from requester 0
    do_reset();
    set0(1'b1, 32'h0000_00F0, 32'h0000_0001, 3'b000);
    wait_got("t1_grant", 4);
    chk("t1_grant_id", 64'(got1), 64'd0);
    set0(1'b0, '0, '0, '0);
    wait_idle("t1_idle", 10);
    chk("t1_ops_done", 64'(ops_done), 64'd1);

    // Both requesters valid from reset: 0 first, then strict alternation
    do_reset();
    set0(1'b1, 32'h0000_00F0, 32'h0000_0001, 3'b001);
    set1(1'b1, 32'h0000_00F0, 32'h0000_0001, 3'b011);
    wait_got("t2_grant", 4);
    chk("t2_first_id", 64'(got1), 64'd0);
    prev = got1;
    for (int k = 0; k < 8; k++) begin
      got0 = 1'b0; got1 = 1'b0;
      wait_got("t2_grant", 8);
      chk("t2_alternate", 64'(got1), 64'(!prev));
      prev = got1;
    end
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    wait_idle("t2_idle", 10);

    // Backpressure in RESP with a competing request waiting
    bus.rsp_ready = 1'b0;
    got0 = 1'b0; got1 = 1'b0;
    set0(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 3'b011);
    wait_got("t3_grant", 8);
    set0(1'b0, '0, '0, '0);
    set1(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
    got0 = 1'b0; got1 = 1'b0;
    repeat (7) tick();
    chk("t3_no_grant", 64'(got0 || got1), 64'd0);
    bus.rsp_ready = 1'b1;
    wait_got("t3_grant_after", 8);
    chk("t3_grant_id", 64'(got1), 64'd1);
    set1(1'b0, '0, '0, '0);
    wait_idle("t3_idle", 10);

    // slt on a negative operand, then and
    got0 = 1'b0; got1 = 1'b0;
    set0(1'b1, 32'h8000_00F0, 32'h0000_0001, 3'b101);
    wait_got("t4_slt", 8);
    set0(1'b0, '0, '0, '0);
    wait_idle("t4_idle", 10);
    got0 = 1'b0; got1 = 1'b0;
    set1(1'b1, 32'h0000_00F0, 32'h0000_0001, 3'b010);
    wait_got("t4_and", 8);
    set1(1'b0, '0, '0, '0);
    wait_idle("t4_idle", 10);

    // Reset during EXEC discards the operation and the round-robin history
    do_reset();
    set0(1'b1, 32'd5, 32'd6, 3'b000);
    wait_got("t5_grant0", 4);
    set0(1'b0, '0, '0, '0);
    wait_idle("t5_idle", 10);
    got0 = 1'b0; got1 = 1'b0;
    set1(1'b1, 32'd7, 32'd8, 3'b000);
    wait_got("t5_grant1", 4);
    set1(1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ops_done", 64'(ops_done), 64'd0);
    repeat (3) tick();
    got0 = 1'b0; got1 = 1'b0;
    set0(1'b1, 32'd1, 32'd2, 3'b011);
    set1(1'b1, 32'd3, 32'd4, 3'b011);
    wait_got("t5_tie", 4);
    chk("t5_tie_id", 64'(got1), 64'd0);
    set0(1'b0, '0, '0, '0);
    repeat (3) tick();
    set1(1'b0, '0, '0, '0);
    wait_idle("t5_idle2", 10);

    // Counter wrap with CNT_W=2: 1,2,3,0,1
    do_reset();
    for (int k = 0; k < 5; k++) begin
      got0 = 1'b0; got1 = 1'b0;
      set0(1'b1, rand_word(), rand_word(), 3'(k));
      wait_got("t6_grant", 4);
      set0(1'b0, '0, '0, '0);
      wait_idle("t6_idle", 10);
      chk("t6_ops_done", 64'(ops_done), 64'((k + 1) % 4));
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 800; c++) begin
      if (got0 || !bus.req0_valid) begin
        got0 = 1'b0;
        set0(($urandom % 100) < 60, rand_word(), rand_word(), 3'($urandom % 8));
      end
      if (got1 || !bus.req1_valid) begin
        got1 = 1'b0;
        set1(($urandom % 100) < 60, rand_word(), rand_word(), 3'($urandom % 8));
      end
      bus.rsp_ready = ($urandom % 100) < 70;
      tick();
    end
    // Let any request still waiting be served, then drain
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (got0) begin got0 = 1'b0; set0(1'b0, '0, '0, '0); end
      if (got1) begin got1 = 1'b0; set1(1'b0, '0, '0, '0); end
      tick();
    end
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    wait_idle("drain", 20);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational 32-bit ALU between two requesters. Uses round-robin arbitration and a valid/ready handshake on both the request and response sides. The ALU is instantiated outside this block and connected through the alu_* ports. This block sequences operand capture, execution and result return, tags each result with the requester index, and counts completed operations.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_op  input  3  requester 0 ALU opcode: 000 sum, 001 sub, 010 and, 011 xor, 101 slt, 100/110/111 pass
req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
alu_a  output  WIDTH  operand a to the ALU
alu_b  output  WIDTH  operand b to the ALU
alu_op  output  3  opcode to the ALU
alu_result  input  WIDTH  ALU result (combinational from alu_*)
alu_cout  input  1  ALU carry-out
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts the response
rsp_id  output  1  requester index for the response
rsp_data  output  WIDTH  captured ALU result
rsp_cout  output  1  captured carry-out
busy  output  1  high in every state except IDLE
ops_done  output  CNT_W  count of completed responses

Behaviour:
- FSM has three states: IDLE, EXEC, RESP. Reset puts it in IDLE.
- Reset values:
  - All outputs are 0, including req*_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, alu_a, alu_b, alu_op, busy and ops_done.
  - The round-robin pointer is reset so that requester 0 wins the first tie.
- IDLE:
  - If no req*_valid is high, stay in IDLE.
  - If exactly one is high, grant that requester.
  - If both are high, grant the requester that was NOT granted last.
  - Grant cycle: reqN_ready=1 for the granted requester only. This is combinational and asserted only in IDLE.
  - On that same edge, register reqN_a, reqN_b and reqN_op into alu_a, alu_b and alu_op; register N as the pending id; move to EXEC.
  - A requester must hold its valid and operands until it sees ready. A requester that is not granted keeps waiting; no request is dropped.
- EXEC (exactly 1 cycle):
  - alu_* are stable, taken from the registers.
  - On the edge, capture alu_result into rsp_data and alu_cout into rsp_cout.
  - Set rsp_id to the pending id, set rsp_valid=1, update the round-robin pointer to the pending id, and move to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_cout are held stable until the handshake.
  - When rsp_valid && rsp_ready: clear rsp_valid, increment ops_done (wraps modulo 2^CNT_W), move to IDLE.
  - If rsp_ready is low, stay in RESP indefinitely (backpressure). No new grant is made while in EXEC or RESP.
- alu_a, alu_b and alu_op hold their last values outside EXEC. They change only on a grant.
- Latency: grant edge to rsp_valid high is 2 clocks. Minimum issue interval is 3 clocks (IDLE, EXEC, RESP with rsp_ready already high).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1 and so on.
- rst high in any state, including mid-EXEC or mid-RESP, returns everything to the reset values on the next edge. The in-flight operation is discarded with no response.
- rsp_ready high while rsp_valid is low has no effect.
- Opcode is passed through unchecked. Pass opcodes are legal.

Test Plan:
1. Reset, then req0 alone with a=0x000000F0, b=0x00000001, op=000 → req0_ready pulses in the grant cycle; 2 clocks later rsp_valid=1, rsp_id=0, rsp_data=0x000000F1, rsp_cout=0; ops_done=1 after the handshake.
2. Both requesters valid from reset (req0 op=001, req1 op=011, same operands) → req0 is served first with rsp_data=0x000000EF. req1 is served next with rsp_data=0x000000F1. Continuous requests alternate ids 0,1,0,1.
3. Backpressure: hold rsp_ready=0 for 5 clocks during RESP → rsp_valid, rsp_id and rsp_data stay stable. req*_ready stays 0 and ops_done does not change. On rsp_ready=1 the handshake completes and the FSM returns to IDLE.
4. slt and and: a=0x800000F0, b=1, op=101 → rsp_data=0x00000001. Then a=0x000000F0, b=1, op=010 → rsp_data=0x00000000.
5. Assert rst while in EXEC → on the next edge rsp_valid=0, busy=0, ops_done=0, with no response emitted. A subsequent simultaneous request grants requester 0 first.
6. Counter wrap: with CNT_W=2, complete 5 operations → ops_done reads 1,2,3,0,1 after each handshake.
